nubus_master_arbctl: RTL and testbench



---
 rtl/nubus_pkg.sv | 16 +
 rtl/nubus_master_arbctl_if.sv | 25 ++
 rtl/nubus_busmon.sv | 24 ++
 rtl/nubus_master_arbctl.sv | 149 ++++++++++++++
 tb/tb_nubus_master_arbctl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: master arbitration controller state encoding and
// default timing constants.
package nubus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_OWN       = 3'd3,
    ST_XFER      = 3'd4
  } arbctl_state_t;

  localparam int ARB_SETTLE_DEFAULT = 2;
  localparam int TIMEOUT_DEFAULT    = 255;

endpackage

// File: rtl/nubus_master_arbctl_if.sv
// Handshake and bus-pin bundle between the card's master FSM, the external
// arbiter, the shared NuBus pins and the arbitration controller.
interface nubus_master_arbctl_if;
  logic mst_req;
  logic mst_lock;
  logic mst_grant;
  logic arb_enable;
  logic arb_grant;
  logic nub_rqstn_o;
  logic nub_rqstn_i;
  logic nub_startn;
  logic nub_ackn;

  // Controller side.
  modport master (
    input  mst_req, mst_lock, arb_grant, nub_rqstn_i, nub_startn, nub_ackn,
    output mst_grant, arb_enable, nub_rqstn_o
  );

  // Environment side: master FSM, arbiter and pin sampling.
  modport slave (
    output mst_req, mst_lock, arb_grant, nub_rqstn_i, nub_startn, nub_ackn,
    input  mst_grant, arb_enable, nub_rqstn_o
  );
endinterface

// File: rtl/nubus_busmon.sv
// NuBus transaction monitor: a transaction is open from /START until /ACK.
// Shared by the master and slave sides of the card.
module nubus_busmon (
  input  logic nub_clkn,
  input  logic nub_resetn,
  input  logic nub_startn,
  input  logic nub_ackn,
  output logic bus_idle
);

  logic tx_active;

  // Track open transaction; /ACK wins so a one-cycle START+ACK leaves it closed.
  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn)     tx_active <= 1'b0;
    else if (!nub_ackn)  tx_active <= 1'b0;
    else if (!nub_startn) tx_active <= 1'b1;
  end

  assign bus_idle = !tx_active && nub_startn;

endmodule

// File: rtl/nubus_master_arbctl.sv
// NuBus master arbitration sequencer: raises /RQST and arbcy, waits for /ARB
// to settle, samples the grant, waits for bus idle and hands the bus to the
// local master. Handles fairness, locked back-to-back ownership and timeout.
module nubus_master_arbctl
  import nubus_pkg::*;
#(
  parameter int ARB_SETTLE = ARB_SETTLE_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  nub_clkn,
  input  logic                  nub_resetn,
  nubus_master_arbctl_if.master bus,
  output logic                  arb_timeout,
  output logic [2:0]            arb_state
);

  // The first cycle arb_enable is high already counts as a settle cycle, so
  // arb_grant is first sampled ARB_SETTLE cycles after arb_enable rises.
  localparam logic [2:0]  SETTLE_LOAD = 3'(ARB_SETTLE - 1);
  localparam logic [15:0] TO_LIMIT    = 16'(TIMEOUT);

  arbctl_state_t state_q, state_d;
  logic [2:0]    settle_q, settle_d;
  logic [15:0]   to_q, to_d, to_inc;
  logic          grant_q, grant_d;
  logic          en_q, en_d;
  logic          rqn_q, rqn_d;
  logic          tmo_q, tmo_d;
  logic          fair_q, fair_d;
  logic          to_expire;
  logic          bus_idle;

  nubus_busmon u_busmon (
    .nub_clkn   (nub_clkn),
    .nub_resetn (nub_resetn),
    .nub_startn (bus.nub_startn),
    .nub_ackn   (bus.nub_ackn),
    .bus_idle   (bus_idle)
  );

  assign to_expire = (TO_LIMIT != 16'd0) && ((to_q + 16'd1) == TO_LIMIT);
  assign to_inc    = (to_q == TO_LIMIT) ? to_q : to_q + 16'd1;

  // Next-state, counter and registered-output decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    settle_d = settle_q;
    to_d     = 16'd0;
    grant_d  = grant_q;
    en_d     = en_q;
    rqn_d    = rqn_q;
    tmo_d    = 1'b0;
    fair_d   = bus.nub_rqstn_i ? 1'b0 : fair_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.mst_req && !fair_q) begin
          state_d  = ST_ARB;
          rqn_d    = 1'b0;
          en_d     = 1'b1;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_ARB: begin
        if (!bus.mst_req || to_expire) begin
          state_d = ST_IDLE;
          rqn_d   = 1'b1;
          en_d    = 1'b0;
          tmo_d   = bus.mst_req;
        end else if (settle_q == 3'd0 && bus.arb_grant) begin
          state_d = ST_WAIT_IDLE;
        end else begin
          to_d = to_inc;
          // A /START on the bus begins a new contest, so settling restarts.
          if (!bus.nub_startn)        settle_d = SETTLE_LOAD;
          else if (settle_q != 3'd0)  settle_d = settle_q - 3'd1;
        end
      end
      ST_WAIT_IDLE: begin
        if (!bus.mst_req || to_expire) begin
          state_d = ST_IDLE;
          rqn_d   = 1'b1;
          en_d    = 1'b0;
          tmo_d   = bus.mst_req;
        end else if (!bus.arb_grant) begin
          state_d  = ST_ARB;
          settle_d = SETTLE_LOAD;
        end else if (bus_idle) begin
          state_d = ST_OWN;
          grant_d = 1'b1;
        end else begin
          to_d = to_inc;
        end
      end
      ST_OWN: begin
        if (!bus.nub_startn) begin
          state_d = ST_XFER;
          grant_d = 1'b0;
          rqn_d   = 1'b1;
          en_d    = 1'b0;
        end
      end
      ST_XFER: begin
        if (!bus.nub_ackn) begin
          if (bus.mst_lock && bus.mst_req) begin
            state_d = ST_OWN;
            grant_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            fair_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      state_q  <= ST_IDLE;
      settle_q <= 3'd0;
      to_q     <= 16'd0;
      grant_q  <= 1'b0;
      en_q     <= 1'b0;
      rqn_q    <= 1'b1;
      tmo_q    <= 1'b0;
      fair_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      to_q     <= to_d;
      grant_q  <= grant_d;
      en_q     <= en_d;
      rqn_q    <= rqn_d;
      tmo_q    <= tmo_d;
      fair_q   <= fair_d;
    end
  end

  assign bus.mst_grant   = grant_q;
  assign bus.arb_enable  = en_q;
  assign bus.nub_rqstn_o = rqn_q;
  assign arb_timeout     = tmo_q;
  assign arb_state       = state_q;

endmodule

// File: tb/tb_nubus_master_arbctl.sv
// Bench: two arbitration controllers (arbiter IDs 3 and 9) on one shared bus,
// plus an optional external contender with ID 12. Directed scenarios followed
// by random traffic, all checked cycle by cycle against a behavioural model.
module tb_nubus_master_arbctl;

  logic nub_clkn = 1'b0;
  logic nub_resetn;
  always #5 nub_clkn = ~nub_clkn;

  nubus_master_arbctl_if bus0 ();
  nubus_master_arbctl_if bus1 ();

  logic       tmo0, tmo1;
  logic [2:0] st0, st1;

  nubus_master_arbctl #(.ARB_SETTLE(2), .TIMEOUT(255)) u_card3 (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .bus(bus0),
    .arb_timeout(tmo0), .arb_state(st0)
  );
  nubus_master_arbctl #(.ARB_SETTLE(3), .TIMEOUT(8)) u_card9 (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .bus(bus1),
    .arb_timeout(tmo1), .arb_state(st1)
  );

  // Stimulus
  logic req [2];
  logic lock [2];
  logic kill [2];
  logic startn, ackn, ext_arb;
  logic rqstn_wire;

  assign bus0.mst_req  = req[0];
  assign bus1.mst_req  = req[1];
  assign bus0.mst_lock = lock[0];
  assign bus1.mst_lock = lock[1];
  assign bus0.nub_startn = startn;
  assign bus1.nub_startn = startn;
  assign bus0.nub_ackn   = ackn;
  assign bus1.nub_ackn   = ackn;
  // Open-collector /RQST: low if any card (or the external one) pulls it.
  assign rqstn_wire = bus0.nub_rqstn_o & bus1.nub_rqstn_o & !ext_arb;
  assign bus0.nub_rqstn_i = rqstn_wire;
  assign bus1.nub_rqstn_i = rqstn_wire;
  // Arbitration: the highest ID among contenders wins (12 > 9 > 3);
  // kill forces a card's grant low.
  assign bus1.arb_grant = bus1.arb_enable && !kill[1] && !ext_arb;
  assign bus0.arb_grant = bus0.arb_enable && !kill[0] && !ext_arb && !bus1.arb_enable;

  // Checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model, from the rules: state numbers 0..4 as published.
  int m_state [2];
  bit m_grant [2], m_en [2], m_rqn [2], m_tmo [2], m_fair [2];
  int m_settle [2];   // cycles until arb_grant may be trusted
  int m_dwell [2];    // cycles spent in current ARB/WAIT_IDLE visit
  bit m_busy;

  function automatic int settle_of(input int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int limit_of(input int i);  return (i == 0) ? 255 : 8; endfunction

  task automatic card_step(input int i, input bit g, input bit idle, input bit rqi);
    int  was, nxt, lim;
    bit  old_fair, give_up;
    if (!nub_resetn) begin
      m_state[i] = 0; m_grant[i] = 0; m_en[i] = 0; m_rqn[i] = 1;
      m_tmo[i] = 0; m_fair[i] = 0; m_settle[i] = 0; m_dwell[i] = 0;
      return;
    end
    was = m_state[i];
    nxt = was;
    lim = limit_of(i);
    old_fair = m_fair[i];
    give_up = 0;
    m_tmo[i] = 0;
    if (rqi) m_fair[i] = 0;
    case (was)
      0: if (req[i] && !old_fair) begin
           nxt = 1; m_rqn[i] = 0; m_en[i] = 1; m_settle[i] = settle_of(i) - 1;
         end
      1: if (!req[i]) give_up = 1;
         else if (lim != 0 && m_dwell[i] + 1 == lim) begin give_up = 1; m_tmo[i] = 1; end
         else if (m_settle[i] == 0 && g) nxt = 2;
         else if (!startn) m_settle[i] = settle_of(i) - 1;
         else if (m_settle[i] > 0) m_settle[i]--;
      2: if (!req[i]) give_up = 1;
         else if (lim != 0 && m_dwell[i] + 1 == lim) begin give_up = 1; m_tmo[i] = 1; end
         else if (!g) begin nxt = 1; m_settle[i] = settle_of(i) - 1; end
         else if (idle) begin nxt = 3; m_grant[i] = 1; end
      3: if (!startn) begin nxt = 4; m_grant[i] = 0; m_rqn[i] = 1; m_en[i] = 0; end
      4: if (!ackn) begin
           if (lock[i] && req[i]) begin nxt = 3; m_grant[i] = 1; end
           else begin nxt = 0; m_fair[i] = 1; end
         end
      default: nxt = 0;
    endcase
    if (give_up) begin nxt = 0; m_rqn[i] = 1; m_en[i] = 0; end
    if (nxt == was && (was == 1 || was == 2))
      m_dwell[i] = (m_dwell[i] + 1 > lim) ? lim : m_dwell[i] + 1;
    else
      m_dwell[i] = 0;
    m_state[i] = nxt;
  endtask

  task automatic model_step();
    bit idle;
    idle = !m_busy && startn;
    card_step(0, bus0.arb_grant, idle, rqstn_wire);
    card_step(1, bus1.arb_grant, idle, rqstn_wire);
    if (!nub_resetn || !ackn) m_busy = 0;
    else if (!startn)         m_busy = 1;
  endtask

  function automatic logic [6:0] dut_vec(input int i);
    if (i == 0) return {st0, bus0.mst_grant, bus0.arb_enable, bus0.nub_rqstn_o, tmo0};
    return {st1, bus1.mst_grant, bus1.arb_enable, bus1.nub_rqstn_o, tmo1};
  endfunction

  function automatic logic [6:0] model_vec(input int i);
    return {3'(m_state[i]), m_grant[i], m_en[i], m_rqn[i], m_tmo[i]};
  endfunction

  // One clock: model consumes the inputs the DUT will sample, then compare
  // at the following falling edge.
  task automatic tick();
    #1 model_step();
    @(negedge nub_clkn);
    check("card3_out", 32'(dut_vec(0)), 32'(model_vec(0)));
    check("card9_out", 32'(dut_vec(1)), 32'(model_vec(1)));
  endtask

  function automatic logic [2:0] state_of(input int i);
    return (i == 0) ? st0 : st1;
  endfunction

  task automatic wait_for(input int i, input int target, input int budget, input string tag);
    int n = 0;
    while (state_of(i) != 3'(target) && n < budget) begin tick(); n++; end
    check(tag, 32'(state_of(i)), 32'(target));
  endtask

  task automatic xfer();
    startn = 0; tick(); startn = 1; tick();
    ackn = 0;   tick(); ackn = 1;   tick();
  endtask

  initial begin
    int n, pulses;
    nub_resetn = 0;
    req = '{0, 0}; lock = '{0, 0}; kill = '{0, 0};
    startn = 1; ackn = 1; ext_arb = 0;
    @(negedge nub_clkn);
    tick(); tick();
    check("reset_card3", 32'(dut_vec(0)), 32'h02);
    check("reset_card9", 32'(dut_vec(1)), 32'h02);
    nub_resetn = 1;
    tick();

    // 1: uncontended request on idle bus
    req[0] = 1;
    tick(); check("t1_rqst_c1", 32'(bus0.nub_rqstn_o), 0);
    tick(); tick(); check("t1_nogrant_c3", 32'(bus0.mst_grant), 0);
    tick(); check("t1_grant_c4", 32'(bus0.mst_grant), 1);
    tick(); startn = 0;
    tick(); check("t1_rqst_rel_c6", 32'(bus0.nub_rqstn_o), 1);
    startn = 1; req[0] = 0; ackn = 0;
    tick(); ackn = 1;
    tick(); tick();

    // 2: two cards contending, fairness afterwards
    req[0] = 1; req[1] = 1;
    wait_for(1, 3, 20, "t2_card9_own");
    check("t2_card3_lost", 32'(st0), 1);
    startn = 0; tick(); startn = 1; tick(); tick(); tick();
    check("t2_card3_wait", 32'(st0), 2);
    ackn = 0; tick(); ackn = 1; tick();
    check("t2_card3_own", 32'(st0), 3);
    check("t2_card9_fair", 32'(st1), 0);
    tick(); tick();
    check("t2_card9_held", 32'(st1), 0);
    startn = 0; tick(); startn = 1; tick(); tick();
    check("t2_card9_rearb", 32'(st1), 1);
    req[0] = 0; ackn = 0; tick(); ackn = 1; tick();
    wait_for(1, 3, 12, "t2_card9_own2");
    req[1] = 0;
    xfer();

    // 3: grant won while another card's transaction is open
    startn = 0; tick(); startn = 1;
    req[0] = 1;
    repeat (6) tick();
    check("t3_wait", 32'(st0), 2);
    check("t3_nogrant", 32'(bus0.mst_grant), 0);
    ackn = 0; tick(); ackn = 1;
    check("t3_hold", 32'(bus0.mst_grant), 0);
    tick();
    check("t3_grant", 32'(bus0.mst_grant), 1);
    req[0] = 0;
    xfer();

    // 4: locked back-to-back ownership
    req[0] = 1; lock[0] = 1;
    wait_for(0, 3, 10, "t4_own");
    for (int k = 0; k < 2; k++) begin
      startn = 0; tick(); startn = 1; tick();
      ackn = 0; tick(); ackn = 1;
      check("t4_own_locked", 32'(st0), 3);
      check("t4_rqst_rel", 32'(bus0.nub_rqstn_o), 1);
      check("t4_arb_off", 32'(bus0.arb_enable), 0);
    end
    lock[0] = 0; req[0] = 0;
    xfer();

    // 5: timeout with grant stuck low, then withdraw
    kill[1] = 1; req[1] = 1;
    tick(); check("t5_arb", 32'(st1), 1);
    n = 0;
    while (n < 20 && !tmo1) begin tick(); n++; end
    check("t5_tmo_delay", 32'(n), 8);
    check("t5_idle", 32'(st1), 0);
    req[1] = 0; kill[1] = 0;
    pulses = 0;
    repeat (4) begin tick(); if (tmo1) pulses++; end
    check("t5_once", 32'(pulses), 0);
    req[0] = 1; tick(); tick();
    check("t5_arb3", 32'(st0), 1);
    req[0] = 0; tick();
    check("t5_withdraw", 32'(st0), 0);
    check("t5_rqst_rel", 32'(bus0.nub_rqstn_o), 1);

    // 6: reset while owning the bus
    req[0] = 1;
    wait_for(0, 3, 10, "t6_own");
    nub_resetn = 0; tick();
    check("t6_reset", 32'(dut_vec(0)), 32'h02);
    nub_resetn = 1; req[0] = 0; tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 15) == 0) req[i]  = ~req[i];
        if ($urandom_range(0, 9) == 0)  lock[i] = ~lock[i];
        if ($urandom_range(0, 39) == 0) kill[i] = ~kill[i];
      end
      if ($urandom_range(0, 29) == 0) ext_arb = ~ext_arb;
      startn     = ($urandom_range(0, 5) != 0);
      ackn       = ($urandom_range(0, 4) != 0);
      nub_resetn = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
